// File: rtl/mult_control_if.sv
// Board/datapath signal bundle for the shift-add multiplier control unit.
// The master side drives the buttons and the multiplier bit; the slave side is the controller.
interface mult_control_if;
    logic Run;
    logic Load_Clear;
    logic M;
    logic Clr_Ld;
    logic Clr_XA;
    logic Add;
    logic Sub;
    logic Shift;
    logic Busy;
    logic Done;

    modport master (
        output Run, Load_Clear, M,
        input  Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done
    );

    modport slave (
        input  Run, Load_Clear, M,
        output Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done
    );
endinterface

// File: rtl/mult_control.sv
// Sequencer for the signed shift-add multiplier: synchronises the buttons and
// issues one-hot datapath strobes (load, clear X:A, add, subtract, shift).
module mult_control #(
    parameter int WIDTH           = 8,
    parameter bit CLEAR_XA_ON_RUN = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    mult_control_if.slave bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLRXA,
        ADD,
        SHIFT,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    logic run_meta, run_s, run_q;
    logic lc_meta, lc_s;

    logic run_rise;
    logic last_iter;

    assign run_rise  = run_s & ~run_q;
    assign last_iter = (count == LAST);

    // Two-flop synchronisers for both buttons, plus a delayed copy of Run for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            run_q    <= 1'b0;
            lc_meta  <= 1'b0;
            lc_s     <= 1'b0;
        end else begin
            run_meta <= bus.Run;
            run_s    <= run_meta;
            run_q    <= run_s;
            lc_meta  <= bus.Load_Clear;
            lc_s     <= lc_meta;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    // Load_Clear wins over a simultaneous Run edge.
                    if (!lc_s && run_rise)
                        state <= CLEAR_XA_ON_RUN ? CLRXA : ADD;
                end
                CLRXA: state <= ADD;
                ADD:   state <= SHIFT;
                SHIFT: begin
                    // Count is held on the final shift so it never wraps; IDLE clears it.
                    if (last_iter) begin
                        state <= HOLD;
                    end else begin
                        state <= ADD;
                        count <= count + CW'(1);
                    end
                end
                HOLD: begin
                    if (!run_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of state (and M in ADD), so reset clears them immediately.
    assign bus.Clr_Ld = lc_s & ((state == IDLE) | (state == HOLD));
    assign bus.Clr_XA = (state == CLRXA);
    assign bus.Add    = (state == ADD) & bus.M & ~last_iter;
    assign bus.Sub    = (state == ADD) & bus.M & last_iter;
    assign bus.Shift  = (state == SHIFT);
    assign bus.Busy   = (state == CLRXA) | (state == ADD) | (state == SHIFT);
    assign bus.Done   = (state == HOLD);

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: a behavioural X:A:B datapath feeds M back, and a
// scoreboard compares strobe pattern, latency and final product per run.
module tb_mult_control;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    mult_control_if bus0 ();
    mult_control_if bus1 ();

    mult_control #(.WIDTH(W), .CLEAR_XA_ON_RUN(1'b1)) dut0 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus0.slave)
    );

    mult_control #(.WIDTH(W), .CLEAR_XA_ON_RUN(1'b0)) dut1 (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus1.slave)
    );

    logic       run_in [2] = '{1'b0, 1'b0};
    logic       lc_in  [2] = '{1'b0, 1'b0};
    logic [7:0] sw     [2] = '{8'h00, 8'h00};
    logic [7:0] s_op   [2] = '{8'h00, 8'h00};
    logic       x_m    [2] = '{1'b0, 1'b0};
    logic [7:0] a_m    [2] = '{8'h00, 8'h00};
    logic [7:0] b_m    [2] = '{8'h00, 8'h00};

    assign bus0.Run        = run_in[0];
    assign bus0.Load_Clear = lc_in[0];
    assign bus0.M          = b_m[0][0];
    assign bus1.Run        = run_in[1];
    assign bus1.Load_Clear = lc_in[1];
    assign bus1.M          = b_m[1][0];

    // Bit order: [4] Clr_Ld, [3] Clr_XA, [2] Add, [1] Sub, [0] Shift
    logic [4:0] st     [2];
    logic       busy_o [2];
    logic       done_o [2];

    assign st[0]     = {bus0.Clr_Ld, bus0.Clr_XA, bus0.Add, bus0.Sub, bus0.Shift};
    assign st[1]     = {bus1.Clr_Ld, bus1.Clr_XA, bus1.Add, bus1.Sub, bus1.Shift};
    assign busy_o[0] = bus0.Busy;
    assign busy_o[1] = bus1.Busy;
    assign done_o[0] = bus0.Done;
    assign done_o[1] = bus1.Done;

    typedef struct {
        logic [7:0]  add_mask;
        logic [7:0]  sub_mask;
        int          clrxa;
        int          lat;
        logic [16:0] xab;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural datapath: X:A:B register with a 9-bit add/subtract of S into X:A.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [8:0] sum;
            if (st[k][4]) begin
                b_m[k] <= sw[k];
                a_m[k] <= 8'h00;
                x_m[k] <= 1'b0;
            end else if (st[k][3]) begin
                a_m[k] <= 8'h00;
                x_m[k] <= 1'b0;
            end else if (st[k][2]) begin
                sum    = {a_m[k][7], a_m[k]} + {s_op[k][7], s_op[k]};
                x_m[k] <= sum[8];
                a_m[k] <= sum[7:0];
            end else if (st[k][1]) begin
                sum    = {a_m[k][7], a_m[k]} - {s_op[k][7], s_op[k]};
                x_m[k] <= sum[8];
                a_m[k] <= sum[7:0];
            end else if (st[k][0]) begin
                a_m[k] <= {x_m[k], a_m[k][7:1]};
                b_m[k] <= {a_m[k][0], b_m[k][7:1]};
            end
        end
    end

    int         starts     [2] = '{0, 0};
    int         shifts     [2] = '{0, 0};
    int         clrxa_seen [2] = '{0, 0};
    int         clrld_cnt  [2] = '{0, 0};
    int         run_cyc    [2] = '{0, 0};
    logic [7:0] add_seen   [2] = '{8'h00, 8'h00};
    logic [7:0] sub_seen   [2] = '{8'h00, 8'h00};
    logic       prev_busy  [2] = '{1'b0, 1'b0};
    logic       prev_done  [2] = '{1'b0, 1'b0};

    // Monitor: records strobes per iteration and scores a run when Done rises.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            check($sformatf("dut%0d strobe_onehot", k), 32'($onehot0(st[k])), 32'd1);
            if (busy_o[k] && !prev_busy[k]) begin
                starts[k]++;
                shifts[k]     = 0;
                clrxa_seen[k] = 0;
                add_seen[k]   = 8'h00;
                sub_seen[k]   = 8'h00;
            end
            if (st[k][4]) clrld_cnt[k]++;
            if (st[k][3]) clrxa_seen[k]++;
            if (st[k][2] && shifts[k] < W) add_seen[k][shifts[k]] = 1'b1;
            if (st[k][1] && shifts[k] < W) sub_seen[k][shifts[k]] = 1'b1;
            if (st[k][0]) shifts[k]++;
            if (done_o[k] && !prev_done[k]) begin
                if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
                    check($sformatf("dut%0d unexpected_done", k), 32'd1, 32'd0);
                end else begin
                    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("dut%0d latency", k), 32'(cyc - run_cyc[k]), 32'(e.lat));
                    check($sformatf("dut%0d add_iters", k), 32'(add_seen[k]), 32'(e.add_mask));
                    check($sformatf("dut%0d sub_iters", k), 32'(sub_seen[k]), 32'(e.sub_mask));
                    check($sformatf("dut%0d shift_count", k), 32'(shifts[k]), 32'd8);
                    check($sformatf("dut%0d clrxa_cycles", k), 32'(clrxa_seen[k]), 32'(e.clrxa));
                    check($sformatf("dut%0d busy_in_hold", k), 32'(busy_o[k]), 32'd0);
                    check($sformatf("dut%0d product_xab", k), 32'({x_m[k], a_m[k], b_m[k]}), 32'(e.xab));
                end
            end
            prev_busy[k] = busy_o[k];
            prev_done[k] = done_o[k];
        end
    end

    task automatic load_b(input int k, input logic [7:0] bval, input logic [7:0] sval);
        sw[k]    = bval;
        s_op[k]  = sval;
        lc_in[k] = 1'b1;
        tick(2);
        lc_in[k] = 1'b0;
        tick(4);
    endtask

    task automatic start_run(input int k, input logic [7:0] bval, input logic [7:0] sval, input bit push);
        exp_t               e;
        logic signed [15:0] p;
        p          = 16'($signed(sval) * $signed(bval));
        e.add_mask = {1'b0, bval[6:0]};
        e.sub_mask = {bval[7], 7'b0};
        e.clrxa    = (k == 0) ? 1 : 0;
        e.lat      = 2 * W + ((k == 0) ? 4 : 3);
        e.xab      = {p[15], p};
        if (push) begin
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        run_cyc[k] = cyc;
        run_in[k]  = 1'b1;
    endtask

    task automatic wait_done(input int k);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick(1);
            if (done_o[k]) got = 1'b1;
        end
        check($sformatf("dut%0d done_reached", k), 32'(got), 32'd1);
    endtask

    task automatic do_mult(input int k, input logic [7:0] bval, input logic [7:0] sval);
        load_b(k, bval, sval);
        start_run(k, bval, sval, 1'b1);
        wait_done(k);
        run_in[k] = 1'b0;
        tick(5);
        check($sformatf("dut%0d idle_after_release", k), 32'(done_o[k]), 32'd0);
    endtask

    initial begin
        int base_ld;
        int base_st;
        int n;

        // Reset state
        tick(3);
        check("reset_strobes", 32'(st[0]), 32'd0);
        check("reset_busy_done", 32'({busy_o[0], done_o[0], busy_o[1], done_o[1]}), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_outputs", 32'({st[0], busy_o[0], done_o[0]}), 32'd0);

        // Load_Clear held 4 cycles with a Run pulse inside the window
        sw[0]   = 8'h07;
        s_op[0] = 8'h07;
        base_ld = clrld_cnt[0];
        base_st = starts[0];
        lc_in[0] = 1'b1;
        tick(1);
        check("clr_ld_sync_lag", 32'(bus0.Clr_Ld), 32'd0);
        run_in[0] = 1'b1;
        tick(1);
        check("clr_ld_rise", 32'(bus0.Clr_Ld), 32'd1);
        run_in[0] = 1'b0;
        tick(2);
        lc_in[0] = 1'b0;
        tick(6);
        check("clr_ld_cycles", 32'(clrld_cnt[0] - base_ld), 32'd4);
        check("run_ignored_under_lc", 32'(starts[0] - base_st), 32'd0);

        // Multiplications: small positive, negative multiplier, most-negative multiplier
        do_mult(0, 8'h07, 8'h07);
        do_mult(0, 8'hC5, 8'h07);
        check("c5x07_ab", 32'({a_m[0], b_m[0]}), 32'h0000_FE63);
        check("c5x07_x", 32'(x_m[0]), 32'd1);

        // Reset during the SHIFT of iteration 3
        load_b(0, 8'hFF, 8'h03);
        start_run(0, 8'hFF, 8'h03, 1'b0);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick(1);
            if (bus0.Shift) n++;
        end
        check("reached_iter3_shift", 32'(n), 32'd4);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({st[0], busy_o[0], done_o[0]}), 32'd0);
        run_in[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_reset_idle", 32'({st[0], busy_o[0], done_o[0]}), 32'd0);
        do_mult(0, 8'h80, 8'h81);

        // Run toggled while busy, then held: one multiplication, Done until release
        load_b(0, 8'h5A, 8'h81);
        base_st = starts[0];
        start_run(0, 8'h5A, 8'h81, 1'b1);
        tick(6);  run_in[0] = 1'b0;
        tick(2);  run_in[0] = 1'b1;
        tick(2);  run_in[0] = 1'b0;
        tick(2);  run_in[0] = 1'b1;
        tick(30);
        check("done_held", 32'(done_o[0]), 32'd1);
        run_in[0] = 1'b0;
        tick(1);
        check("done_release_e0", 32'(done_o[0]), 32'd1);
        tick(1);
        check("done_release_e1", 32'(done_o[0]), 32'd1);
        tick(1);
        check("done_release_e2", 32'(done_o[0]), 32'd0);
        tick(5);
        check("single_mult_per_press", 32'(starts[0] - base_st), 32'd1);
        check("dut0 scoreboard_empty", 32'(sb0.size()), 32'd0);

        // Build without the CLRXA state
        do_mult(1, 8'hC5, 8'h07);
        check("dut1 c5x07_ab", 32'({a_m[1], b_m[1]}), 32'h0000_FE63);
        check("dut1 scoreboard_empty", 32'(sb1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
